// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding, BCD limits, digit type.
package timer_pkg;

  localparam int P_DIG_W   = 4;
  localparam int P_BCD_MAX = 9;
  localparam int P_MAX_ST  = 5;
  localparam int P_MAX_MT  = 5;

  typedef logic [P_DIG_W-1:0] digit_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // True when a BCD digit does not exceed the given limit.
  function automatic logic digit_ok(input digit_t d, input digit_t lim);
    return (d <= lim);
  endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Command, preset and display bundle between the timer controller and its surroundings.
interface timer_ctrl_if #(
  parameter int DIG_W = 4
);

  logic             seg_in;
  logic             start;
  logic             pause;
  logic             clear;
  logic             load;
  logic [DIG_W-1:0] ld_mt;
  logic [DIG_W-1:0] ld_mo;
  logic [DIG_W-1:0] ld_st;
  logic [DIG_W-1:0] ld_so;
  logic [DIG_W-1:0] mt;
  logic [DIG_W-1:0] mo;
  logic [DIG_W-1:0] st;
  logic [DIG_W-1:0] so;
  logic [1:0]       state_o;
  logic             alarm;
  logic             done_pulse;
  logic             load_err;

  modport slave (
    input  seg_in, start, pause, clear, load, ld_mt, ld_mo, ld_st, ld_so,
    output mt, mo, st, so, state_o, alarm, done_pulse, load_err
  );

  modport master (
    output seg_in, start, pause, clear, load, ld_mt, ld_mo, ld_st, ld_so,
    input  mt, mo, st, so, state_o, alarm, done_pulse, load_err
  );

endinterface

// File: rtl/bcd_digit_down.sv
// One BCD down-counting digit with parallel load and borrow output for chaining.
module bcd_digit_down #(
  parameter int MAXV  = 9,
  parameter int DIG_W = 4
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             ld,
  input  logic [DIG_W-1:0] ld_val,
  input  logic             dec,
  output logic [DIG_W-1:0] q,
  output logic             borrow_out
);

  localparam logic [DIG_W-1:0] LP_MAXV = DIG_W'(MAXV);

  logic [DIG_W-1:0] r_q;

  // Load takes precedence over decrement; decrementing from zero wraps to MAXV.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (dec) begin
      if (r_q == '0) begin
        r_q <= LP_MAXV;
      end else begin
        r_q <= r_q - 1'b1;
      end
    end
  end

  assign q          = r_q;
  assign borrow_out = dec & (r_q == '0);

endmodule

// File: rtl/timer_ctrl.sv
// Countdown timer controller (mm:ss). Optional macro TIMER_ALARM_BLINK_EN makes the
// alarm follow the 1 Hz seg_in wave while DONE instead of holding steady high.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int MAX_MT = P_MAX_MT,
  parameter int MAX_ST = P_MAX_ST,
  parameter int DIG_W  = P_DIG_W
) (
  input  logic          mclk,
  input  logic          reset,
  timer_ctrl_if.slave   bus
);

  localparam logic [DIG_W-1:0] LP_NINE   = DIG_W'(P_BCD_MAX);
  localparam logic [DIG_W-1:0] LP_MAX_ST = DIG_W'(MAX_ST);
  localparam logic [DIG_W-1:0] LP_MAX_MT = DIG_W'(MAX_MT);
  localparam logic [DIG_W-1:0] LP_ONE    = DIG_W'(1);

  state_t r_state;
  state_t w_next;

  logic r_seg_prev;
  logic r_start_prev;
  logic r_pause_prev;
  logic r_done_pulse;
  logic r_load_err;

  logic [DIG_W-1:0] r_pre_mt;
  logic [DIG_W-1:0] r_pre_mo;
  logic [DIG_W-1:0] r_pre_st;
  logic [DIG_W-1:0] r_pre_so;

  logic [DIG_W-1:0] w_mt;
  logic [DIG_W-1:0] w_mo;
  logic [DIG_W-1:0] w_st;
  logic [DIG_W-1:0] w_so;

  logic w_tick;
  logic w_start_re;
  logic w_pause_re;
  logic w_ld_legal;
  logic w_zero;
  logic w_one;
  logic w_dec;
  logic w_load_dig;
  logic w_use_ld;
  logic w_set_preset;
  logic w_lerr;
  logic w_borrow_so;
  logic w_borrow_st;
  logic w_borrow_mo;
  logic w_borrow_mt;

  assign w_tick     = bus.seg_in & ~r_seg_prev;
  assign w_start_re = bus.start  & ~r_start_prev;
  assign w_pause_re = bus.pause  & ~r_pause_prev;

  assign w_ld_legal = digit_ok(bus.ld_mt, LP_MAX_MT) && digit_ok(bus.ld_mo, LP_NINE) &&
                      digit_ok(bus.ld_st, LP_MAX_ST) && digit_ok(bus.ld_so, LP_NINE);

  assign w_zero = (w_mt == '0) && (w_mo == '0) && (w_st == '0) && (w_so == '0);
  assign w_one  = (w_mt == '0) && (w_mo == '0) && (w_st == '0) && (w_so == LP_ONE);

  // Previous-cycle samples of seg_in/start/pause so each rising edge acts exactly once.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_seg_prev   <= 1'b0;
      r_start_prev <= 1'b0;
      r_pause_prev <= 1'b0;
    end else begin
      r_seg_prev   <= bus.seg_in;
      r_start_prev <= bus.start;
      r_pause_prev <= bus.pause;
    end
  end

  // State register.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath controls; clear beats the terminal tick, which beats load/start/pause.
  always_comb begin
    w_next       = r_state;
    w_dec        = 1'b0;
    w_load_dig   = 1'b0;
    w_use_ld     = 1'b0;
    w_set_preset = 1'b0;
    w_lerr       = 1'b0;

    // A tick while running always decrements unless clear aborts in the same cycle.
    if ((r_state == ST_RUN) && w_tick && !bus.clear) begin
      w_dec = 1'b1;
    end

    if (bus.clear) begin
      w_next     = ST_IDLE;
      w_load_dig = 1'b1;
    end else if (w_dec && (w_one || w_borrow_mt)) begin
      // w_borrow_mt only fires on an underflow that the FSM never allows; treat it as terminal too.
      w_next = ST_DONE;
    end else if (bus.load) begin
      if ((r_state == ST_IDLE) || (r_state == ST_DONE)) begin
        if (w_ld_legal) begin
          w_next       = ST_IDLE;
          w_load_dig   = 1'b1;
          w_use_ld     = 1'b1;
          w_set_preset = 1'b1;
        end else begin
          w_lerr = 1'b1;
        end
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start_re && !w_zero) begin
            w_next = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_pause_re) begin
            w_next = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (w_start_re || w_pause_re) begin
            w_next = ST_RUN;
          end
        end
        default: begin
          w_next = r_state;
        end
      endcase
    end
  end

  // Preset capture on a legal load; the preset survives clear but not reset.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_pre_mt <= '0;
      r_pre_mo <= '0;
      r_pre_st <= '0;
      r_pre_so <= '0;
    end else if (w_set_preset) begin
      r_pre_mt <= bus.ld_mt;
      r_pre_mo <= bus.ld_mo;
      r_pre_st <= bus.ld_st;
      r_pre_so <= bus.ld_so;
    end
  end

  // One-cycle status pulses aligned with the state change they report.
  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_done_pulse <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_done_pulse <= (w_next == ST_DONE) && (r_state != ST_DONE);
      r_load_err   <= w_lerr;
    end
  end

  bcd_digit_down #(.MAXV(P_BCD_MAX), .DIG_W(DIG_W)) u_so (
    .mclk       (mclk),
    .reset      (reset),
    .ld         (w_load_dig),
    .ld_val     (w_use_ld ? bus.ld_so : r_pre_so),
    .dec        (w_dec),
    .q          (w_so),
    .borrow_out (w_borrow_so)
  );

  bcd_digit_down #(.MAXV(MAX_ST), .DIG_W(DIG_W)) u_st (
    .mclk       (mclk),
    .reset      (reset),
    .ld         (w_load_dig),
    .ld_val     (w_use_ld ? bus.ld_st : r_pre_st),
    .dec        (w_borrow_so),
    .q          (w_st),
    .borrow_out (w_borrow_st)
  );

  bcd_digit_down #(.MAXV(P_BCD_MAX), .DIG_W(DIG_W)) u_mo (
    .mclk       (mclk),
    .reset      (reset),
    .ld         (w_load_dig),
    .ld_val     (w_use_ld ? bus.ld_mo : r_pre_mo),
    .dec        (w_borrow_st),
    .q          (w_mo),
    .borrow_out (w_borrow_mo)
  );

  bcd_digit_down #(.MAXV(MAX_MT), .DIG_W(DIG_W)) u_mt (
    .mclk       (mclk),
    .reset      (reset),
    .ld         (w_load_dig),
    .ld_val     (w_use_ld ? bus.ld_mt : r_pre_mt),
    .dec        (w_borrow_mo),
    .q          (w_mt),
    .borrow_out (w_borrow_mt)
  );

  assign bus.mt         = w_mt;
  assign bus.mo         = w_mo;
  assign bus.st         = w_st;
  assign bus.so         = w_so;
  assign bus.state_o    = r_state;
  assign bus.done_pulse = r_done_pulse;
  assign bus.load_err   = r_load_err;

`ifdef TIMER_ALARM_BLINK_EN
  assign bus.alarm = (r_state == ST_DONE) & bus.seg_in;
`else
  assign bus.alarm = (r_state == ST_DONE);
`endif

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
- Countdown timer controller (mm:ss, max 59:59).
- Sequences the 1 s square wave from the seconds counter into a preset/start/pause/clear timer.
- Drives four BCD digits to the display mux and raises an alarm at 00:00.
- Same mclk domain as the seconds counter; no synchronizer required.

Parameters:
- MAX_MT, 5, highest legal minutes-tens digit on load.
- MAX_ST, 5, highest legal seconds-tens digit (borrow reload value).
- DIG_W, 4, width of each BCD digit port.

Ports:
- mclk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- seg_in  in  1  1 s square wave; each rising edge = one second tick
- start  in  1  level, sampled each cycle; start/resume request
- pause  in  1  level, sampled each cycle; toggle RUN/PAUSE
- clear  in  1  abort, restore preset
- load  in  1  capture ld_* as new preset
- ld_mt  in  4  preset minutes tens (BCD)
- ld_mo  in  4  preset minutes ones (BCD)
- ld_st  in  4  preset seconds tens (BCD)
- ld_so  in  4  preset seconds ones (BCD)
- mt, mo, st, so  out  4 each  current digits
- state_o  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3
- alarm  out  1  high while in DONE
- done_pulse  out  1  one-cycle pulse on entry to DONE
- load_err  out  1  one-cycle pulse on a rejected load

Behaviour:
- Reset (reset=0, async): digits and preset = 0, state IDLE, alarm/done_pulse/load_err = 0, seg_prev = 0.
- Tick: tick = seg_in & ~seg_prev. seg_prev is registered every cycle, so tick is high exactly 1 cycle per seg_in rising edge.
- Command priority per cycle: clear > load > start > pause. Lower-priority commands in the same cycle are ignored.
- clear, any state: state -> IDLE, digits <= preset, alarm = 0.
- load, legal only in IDLE/DONE:
  - Digits legal (mt<=MAX_MT, mo<=9, st<=MAX_ST, so<=9): preset and digits <= ld_*, state -> IDLE.
  - Any digit illegal: preset and digits unchanged, load_err = 1 for 1 cycle.
  - In RUN/PAUSE: load ignored silently, no load_err.
- IDLE + start: digits nonzero -> RUN; digits 00:00 -> stay IDLE.
- RUN + pause -> PAUSE. PAUSE + pause -> RUN. PAUSE + start -> RUN.
- Edge commands: pause/start are edge-detected internally (rising edge acts once). A held level does not re-toggle.
- RUN + tick: BCD decrement with borrow.
  - so 0->9 borrows st; st 0->MAX_ST borrows mo; mo 0->9 borrows mt; mt decrements.
  - Update happens on the same edge as the tick cycle.
- Terminal count: RUN + tick with digits 00:01 -> digits 00:00 and state DONE on the same edge. done_pulse is high in the first DONE cycle only. alarm = 1 from that cycle on.
- PAUSE: ticks ignored. After resume, first decrement occurs at the next tick; partial-second loss is accepted.
- DONE: ticks ignored, digits held at 00:00. start in DONE is ignored. Exit only via clear or legal load.
- Simultaneous tick and clear: clear wins; no decrement.
- Simultaneous tick and pause in RUN: decrement applied, then state PAUSE.
- Reset mid-RUN: immediate return to reset values; preset is lost.

Optional Feature:
- Macro TIMER_ALARM_BLINK_EN.
- Defined: in DONE, alarm = seg_in, gated with state==DONE (blinks at 1 Hz).
- Undefined: alarm steady 1 in DONE.
- done_pulse is identical in both builds.

Decomposition:
- Shared package timer_pkg:
  - state encoding constants (IDLE/RUN/PAUSE/DONE, 2 bits)
  - BCD limit constants (9, MAX_ST, MAX_MT)
  - digit type of DIG_W bits
- Sub-module bcd_digit_down (one instance per digit).
  - Params: MAXV.
  - Inputs: mclk, reset, ld, ld_val, dec.
  - Outputs: q, borrow_out, where borrow_out = dec & (q==0).
  - Wrap: on dec with q==0, q <= MAXV.
- timer_ctrl chains the four instances and holds the FSM, tick and edge detection, and load validation.

Test Plan:
- Reset then load 00:03, start, 3 ticks -> digits 00:02, 00:01, 00:00; state_o 1,1,3; done_pulse 1 cycle on the third; alarm=1.
- Load 10:00, start, 1 tick -> digits 09:59 (full borrow chain); second tick -> 09:58.
- Load 01:30, start, tick -> 01:29; pause, 2 ticks -> still 01:29, state 2; pause again, tick -> 01:28, state 1.
- Load with ld_st=6 -> load_err pulse, digits/preset unchanged. Load 00:00 then start -> state stays 0.
- Load 05:00, start, 2 ticks (04:58), clear asserted in the same cycle as a tick -> digits 05:00, state 0, no decrement.
- Run 00:01 to DONE, assert reset low mid-DONE -> all outputs 0 asynchronously. With TIMER_ALARM_BLINK_EN, alarm follows seg_in in DONE.
